// File: rtl/snoopy_axis_motion.sv
// snoopy_axis_motion: single-axis sprite motion controller.
// Position advances by a signed speed once per move_tick; speed ramps up
// while a direction is held and decays through a BRAKE state on release.
// Configuration macro: SNOOPY_AXIS_WRAP_EN
//   undefined -> position clamps at 0 / MAX_POS and a bound hit stops motion
//   defined   -> toroidal playfield, position wraps and motion continues
module snoopy_axis_motion #(
  parameter int POS_W       = 8,
  parameter int MAX_POS     = 160,
  parameter int START_POS   = 0,
  parameter int SPD_W       = 4,
  parameter int MAX_SPEED   = 3,
  parameter int ACCEL_TICKS = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             move_tick,
  input  logic             input_neg,
  input  logic             input_pos,
  output logic [POS_W-1:0] pos,
  output logic [SPD_W-1:0] speed,
  output logic             moving,
  output logic             at_min,
  output logic             at_max
);

  localparam int SUM_W = POS_W + 2;
  localparam int ACC_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [ACC_W-1:0]        ACC_LAST  = ACC_W'(ACCEL_TICKS - 1);
  // The tick that enters BRAKE already counts as the first braking tick, so
  // the first speed step happens ACCEL_TICKS ticks after release.
  localparam logic [ACC_W-1:0]        ACC_BRAKE_ENTRY = (ACCEL_TICKS > 1) ? ACC_W'(1) : '0;
  localparam logic [ACC_W-1:0]        ACC_ONE   = ACC_W'(1);
  localparam logic [POS_W-1:0]        POS_MAX   = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0]        POS_START = POS_W'(START_POS);
  localparam logic signed [SUM_W-1:0] SUM_MAX   = SUM_W'(MAX_POS);
  localparam logic signed [SPD_W-1:0] SPD_MAX   = SPD_W'(MAX_SPEED);
  localparam logic signed [SPD_W-1:0] SPD_MIN   = -SPD_W'(MAX_SPEED);
  localparam logic signed [SPD_W-1:0] SPD_ONE   = SPD_W'(1);
  localparam logic signed [SPD_W-1:0] SPD_ZERO  = '0;
`ifdef SNOOPY_AXIS_WRAP_EN
  localparam logic signed [SUM_W-1:0] WRAP_SPAN = SUM_W'(MAX_POS + 1);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_P = 2'd1,
    MOVE_N = 2'd2,
    BRAKE  = 2'd3
  } state_t;

  state_t                   state_reg;
  logic [POS_W-1:0]         pos_reg;
  logic signed [SPD_W-1:0]  speed_reg;
  logic [ACC_W-1:0]         acc_reg;

  logic [POS_W-1:0]         pos_next;
  logic                     bound_hit;
  logic signed [SUM_W-1:0]  sum;
  logic                     req_pos;
  logic                     req_neg;
  logic                     start_pos_ok;
  logic                     start_neg_ok;

  // Conflicting or absent inputs both mean "no request".
  assign req_pos = input_pos & ~input_neg;
  assign req_neg = input_neg & ~input_pos;

  assign at_min = (pos_reg == '0);
  assign at_max = (pos_reg == POS_MAX);

`ifdef SNOOPY_AXIS_WRAP_EN
  assign start_pos_ok = req_pos;
  assign start_neg_ok = req_neg;
`else
  // A request pushing into a bound that is already reached is ignored.
  assign start_pos_ok = req_pos & ~at_max;
  assign start_neg_ok = req_neg & ~at_min;
`endif

  // Two guard bits on the sum let both underflow and overflow show up.
  assign sum = $signed({2'b00, pos_reg}) + SUM_W'(speed_reg);

  // Position update from the pre-tick speed, with clamp or wrap at the edges.
  always_comb begin
    pos_next  = POS_W'(sum);
    bound_hit = 1'b0;
    if (sum > SUM_MAX) begin
`ifdef SNOOPY_AXIS_WRAP_EN
      pos_next  = POS_W'(sum - WRAP_SPAN);
`else
      pos_next  = POS_MAX;
      bound_hit = 1'b1;
`endif
    end else if (sum[SUM_W-1]) begin
`ifdef SNOOPY_AXIS_WRAP_EN
      pos_next  = POS_W'(sum + WRAP_SPAN);
`else
      pos_next  = '0;
      bound_hit = 1'b1;
`endif
    end
  end

  // Motion FSM: everything advances only on move_tick.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      pos_reg   <= POS_START;
      speed_reg <= SPD_ZERO;
      acc_reg   <= '0;
    end else if (move_tick) begin
      pos_reg <= pos_next;
      case (state_reg)
        IDLE: begin
          speed_reg <= SPD_ZERO;
          acc_reg   <= '0;
          if (start_pos_ok) begin
            state_reg <= MOVE_P;
            speed_reg <= SPD_ONE;
          end else if (start_neg_ok) begin
            state_reg <= MOVE_N;
            speed_reg <= -SPD_ONE;
          end
        end
        MOVE_P: begin
          if (req_pos) begin
            if (acc_reg == ACC_LAST) begin
              acc_reg <= '0;
              if (speed_reg < SPD_MAX) speed_reg <= speed_reg + SPD_ONE;
            end else begin
              acc_reg <= acc_reg + ACC_ONE;
            end
          end else begin
            state_reg <= BRAKE;
            acc_reg   <= ACC_BRAKE_ENTRY;
          end
        end
        MOVE_N: begin
          if (req_neg) begin
            if (acc_reg == ACC_LAST) begin
              acc_reg <= '0;
              if (speed_reg > SPD_MIN) speed_reg <= speed_reg - SPD_ONE;
            end else begin
              acc_reg <= acc_reg + ACC_ONE;
            end
          end else begin
            state_reg <= BRAKE;
            acc_reg   <= ACC_BRAKE_ENTRY;
          end
        end
        default: begin
          // BRAKE: only the request matching the current direction resumes.
          if (speed_reg == SPD_ZERO) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
          end else if ((speed_reg > SPD_ZERO) && req_pos) begin
            state_reg <= MOVE_P;
            acc_reg   <= '0;
          end else if ((speed_reg < SPD_ZERO) && req_neg) begin
            state_reg <= MOVE_N;
            acc_reg   <= '0;
          end else if (acc_reg == ACC_LAST) begin
            acc_reg <= '0;
            if (speed_reg > SPD_ZERO) speed_reg <= speed_reg - SPD_ONE;
            else                      speed_reg <= speed_reg + SPD_ONE;
            if ((speed_reg == SPD_ONE) || (speed_reg == -SPD_ONE)) state_reg <= IDLE;
          end else begin
            acc_reg <= acc_reg + ACC_ONE;
          end
        end
      endcase
      // Hitting a bound stops the sprite dead, overriding the FSM above.
      if (bound_hit) begin
        state_reg <= IDLE;
        speed_reg <= SPD_ZERO;
        acc_reg   <= '0;
      end
    end
  end

  assign pos    = pos_reg;
  assign speed  = speed_reg;
  assign moving = (speed_reg != SPD_ZERO);

endmodule

// File: tb/tb_snoopy_axis_motion.sv
// Directed bench for snoopy_axis_motion with default parameters
// (clamped playfield, MAX_POS=160, MAX_SPEED=3, ACCEL_TICKS=2).
module tb_snoopy_axis_motion;

  logic       clock;
  logic       resetn;
  logic       move_tick;
  logic       input_neg;
  logic       input_pos;
  logic [7:0] pos;
  logic [3:0] speed;
  logic       moving;
  logic       at_min;
  logic       at_max;

  int n_tests;
  int n_fail;
  int step;

  typedef struct {
    logic       neg;
    logic       psh;
    int         e_pos;
    int         e_spd;
    logic       e_min;
    logic       e_max;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  snoopy_axis_motion dut (
    .clock     (clock),
    .resetn    (resetn),
    .move_tick (move_tick),
    .input_neg (input_neg),
    .input_pos (input_pos),
    .pos       (pos),
    .speed     (speed),
    .moving    (moving),
    .at_min    (at_min),
    .at_max    (at_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic neg, input logic psh, input int p, input int s);
    vec_t v;
    v.neg   = neg;
    v.psh   = psh;
    v.e_pos = p;
    v.e_spd = s;
    v.e_min = (p == 0);
    v.e_max = (p == 160);
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0d, expected %0d", step, name, actual, expected);
    end
  endtask

  task automatic check_all(input int e_pos, input int e_spd, input logic e_min, input logic e_max);
    check("pos",    int'(pos),            e_pos);
    check("speed",  int'($signed(speed)), e_spd);
    check("moving", int'(moving),         int'(e_spd != 0));
    check("at_min", int'(at_min),         int'(e_min));
    check("at_max", int'(at_max),         int'(e_max));
    $display("[TB] step %0d: pos=%0d speed=%0d moving=%0b at_min=%0b at_max=%0b",
             step, pos, $signed(speed), moving, at_min, at_max);
  endtask

  // One move_tick pulse with the given inputs; outputs sampled at the next negedge.
  task automatic tick(input logic neg, input logic psh);
    @(negedge clock);
    input_neg = neg;
    input_pos = psh;
    move_tick = 1'b1;
    @(negedge clock);
    move_tick = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    step++;
    tick(v.neg, v.psh);
    check_all(v.e_pos, v.e_spd, v.e_min, v.e_max);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    step    = 0;

    // Push into the lower bound from IDLE: ignored.
    tbl_a.push_back(mk(1, 0, 0, 0));
    // Acceleration from reset.
    tbl_a.push_back(mk(0, 1, 0, 1));
    tbl_a.push_back(mk(0, 1, 1, 1));
    tbl_a.push_back(mk(0, 1, 2, 2));
    tbl_a.push_back(mk(0, 1, 4, 2));
    tbl_a.push_back(mk(0, 1, 6, 3));
    tbl_a.push_back(mk(0, 1, 9, 3));
    tbl_a.push_back(mk(0, 1, 12, 3));
    // Release and brake down to IDLE.
    tbl_a.push_back(mk(0, 0, 15, 3));
    tbl_a.push_back(mk(0, 0, 18, 2));
    tbl_a.push_back(mk(0, 0, 20, 2));
    tbl_a.push_back(mk(0, 0, 22, 1));
    tbl_a.push_back(mk(0, 0, 23, 1));
    tbl_a.push_back(mk(0, 0, 24, 0));
    // Single-tick tap then release.
    tbl_a.push_back(mk(0, 1, 24, 1));
    tbl_a.push_back(mk(0, 0, 25, 1));
    tbl_a.push_back(mk(0, 0, 26, 0));
    // Re-accelerate to cruise.
    tbl_a.push_back(mk(0, 1, 26, 1));
    tbl_a.push_back(mk(0, 1, 27, 1));
    tbl_a.push_back(mk(0, 1, 28, 2));
    tbl_a.push_back(mk(0, 1, 30, 2));
    tbl_a.push_back(mk(0, 1, 32, 3));
    tbl_a.push_back(mk(0, 1, 35, 3));
    tbl_a.push_back(mk(0, 1, 38, 3));

    // Upper bound hit from 158 at speed 3, then held against the bound.
    tbl_b.push_back(mk(0, 1, 160, 0));
    tbl_b.push_back(mk(0, 1, 160, 0));
    tbl_b.push_back(mk(0, 1, 160, 0));
    // Move negative, then both pressed at speed -2, then opposite request.
    tbl_b.push_back(mk(1, 0, 160, -1));
    tbl_b.push_back(mk(1, 0, 159, -1));
    tbl_b.push_back(mk(1, 0, 158, -2));
    tbl_b.push_back(mk(1, 0, 156, -2));
    tbl_b.push_back(mk(1, 1, 154, -2));
    tbl_b.push_back(mk(0, 1, 152, -1));
    tbl_b.push_back(mk(0, 1, 151, -1));
    tbl_b.push_back(mk(0, 1, 150, 0));
    tbl_b.push_back(mk(0, 1, 150, 1));
    tbl_b.push_back(mk(0, 1, 151, 1));
    // Release into BRAKE, then resume with the same-direction request.
    tbl_b.push_back(mk(0, 0, 152, 1));
    tbl_b.push_back(mk(0, 1, 153, 1));
    tbl_b.push_back(mk(0, 1, 154, 1));
    tbl_b.push_back(mk(0, 1, 155, 2));

    resetn    = 1'b0;
    move_tick = 1'b0;
    input_neg = 1'b0;
    input_pos = 1'b0;
    repeat (3) @(negedge clock);
    check_all(0, 0, 1'b1, 1'b0);
    resetn = 1'b1;
    @(negedge clock);

    foreach (tbl_a[i]) run_vec(tbl_a[i]);

    // Cruise at speed 3 from 38 up to 158.
    for (int k = 1; k <= 40; k++) begin
      step++;
      tick(1'b0, 1'b1);
      check_all(38 + 3 * k, 3, 1'b0, 1'b0);
    end

    foreach (tbl_b[i]) run_vec(tbl_b[i]);

    // No move_tick: state holds regardless of inputs.
    step++;
    @(negedge clock);
    input_neg = 1'b1;
    input_pos = 1'b0;
    repeat (3) @(negedge clock);
    check_all(155, 2, 1'b0, 1'b0);

    // Asynchronous reset mid-motion, between clock edges, with move_tick high.
    step++;
    input_neg = 1'b0;
    input_pos = 1'b1;
    move_tick = 1'b1;
    #2 resetn = 1'b0;
    #1 check_all(0, 0, 1'b1, 1'b0);
    @(negedge clock);
    move_tick = 1'b0;
    resetn    = 1'b1;
    step++;
    repeat (3) @(negedge clock);
    check_all(0, 0, 1'b1, 1'b0);
    step++;
    tick(1'b0, 1'b1);
    check_all(0, 1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
